// File: rtl/glove_locator_if.sv
// rtl/glove_locator_if.sv - pixel-stream inputs and glove-result outputs of glove_locator
// The master side drives XVGA timing and camera pixels; the slave side returns published centroids.
interface glove_locator_if;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        vsync;
  logic        blank;
  logic [23:0] pixel;
  logic [10:0] glove1x;
  logic [9:0]  glove1y;
  logic [10:0] glove2x;
  logic [9:0]  glove2y;
  logic        glove1_valid;
  logic        glove2_valid;
  logic        done;
  logic        busy;

  modport master (
    output hcount, vcount, vsync, blank, pixel,
    input  glove1x, glove1y, glove2x, glove2y, glove1_valid, glove2_valid, done, busy
  );

  modport slave (
    input  hcount, vcount, vsync, blank, pixel,
    output glove1x, glove1y, glove2x, glove2y, glove1_valid, glove2_valid, done, busy
  );
endinterface

// File: rtl/glove_locator.sv
// rtl/glove_locator.sv - red/green marker centroid finder with a shared restoring divider
// Sums marker pixel coordinates per frame, then divides them out at the vsync falling edge.
module glove_locator #(
  parameter logic [7:0]  HI_MIN    = 8'd160,
  parameter logic [7:0]  LO_MAX    = 8'd80,
  parameter logic [19:0] MIN_COUNT = 20'd64
) (
  input logic            vclock,
  input logic            reset,
  glove_locator_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_G1X,
    S_G1Y,
    S_G2X,
    S_G2Y,
    S_PUB
  } state_t;

  state_t      r_state;
  logic        r_vsync_d;
  logic [4:0]  r_step;

  logic [29:0] r_sumx1, r_sumy1, r_sumx2, r_sumy2;
  logic [19:0] r_cnt1, r_cnt2;

  logic [29:0] r_op_sx1, r_op_sy1, r_op_sx2, r_op_sy2;
  logic [19:0] r_op_c1, r_op_c2;

  logic [19:0] r_rem;
  logic [29:0] r_quo;
  logic [19:0] r_dvs;

  logic [10:0] r_q1x, r_q2x;
  logic [9:0]  r_q1y;

  logic [10:0] r_g1x, r_g2x;
  logic [9:0]  r_g1y, r_g2y;
  logic        r_v1, r_v2, r_done, r_busy;

  logic [7:0]  w_r, w_g, w_b;
  logic        w_is_g1, w_is_g2, w_edge, w_snap;
  logic [29:0] w_dividend;
  logic [19:0] w_divisor, w_divisor_f;
  logic [20:0] w_shift;
  logic        w_ge;
  logic [19:0] w_rem_n;
  logic [29:0] w_quo_n;

  assign w_r = bus.pixel[23:16];
  assign w_g = bus.pixel[15:8];
  assign w_b = bus.pixel[7:0];

  assign w_is_g1 = !bus.blank && (w_r >= HI_MIN) && (w_g <= LO_MAX) && (w_b <= LO_MAX);
  assign w_is_g2 = !bus.blank && (w_g >= HI_MIN) && (w_r <= LO_MAX) && (w_b <= LO_MAX);

  // Edges seen outside IDLE are ignored so that frame simply merges into the next.
  assign w_edge = r_vsync_d && !bus.vsync;
  assign w_snap = w_edge && (r_state == S_IDLE);

  always_ff @(posedge vclock) begin
    if (reset) begin
      r_sumx1 <= '0;
      r_sumy1 <= '0;
      r_cnt1  <= '0;
      r_sumx2 <= '0;
      r_sumy2 <= '0;
      r_cnt2  <= '0;
    end else if (w_snap) begin
      r_sumx1 <= '0;
      r_sumy1 <= '0;
      r_cnt1  <= '0;
      r_sumx2 <= '0;
      r_sumy2 <= '0;
      r_cnt2  <= '0;
    end else begin
      if (w_is_g1) begin
        r_sumx1 <= r_sumx1 + {19'd0, bus.hcount};
        r_sumy1 <= r_sumy1 + {20'd0, bus.vcount};
        r_cnt1  <= r_cnt1 + 20'd1;
      end
      if (w_is_g2) begin
        r_sumx2 <= r_sumx2 + {19'd0, bus.hcount};
        r_sumy2 <= r_sumy2 + {20'd0, bus.vcount};
        r_cnt2  <= r_cnt2 + 20'd1;
      end
    end
  end

  always_comb begin
    w_dividend = '0;
    w_divisor  = '0;
    case (r_state)
      S_G1X: begin w_dividend = r_op_sx1; w_divisor = r_op_c1; end
      S_G1Y: begin w_dividend = r_op_sy1; w_divisor = r_op_c1; end
      S_G2X: begin w_dividend = r_op_sx2; w_divisor = r_op_c2; end
      S_G2Y: begin w_dividend = r_op_sy2; w_divisor = r_op_c2; end
      default: begin w_dividend = '0; w_divisor = '0; end
    endcase
    // An empty glove still runs its divides for fixed latency; avoid divide-by-zero.
    w_divisor_f = (w_divisor == 20'd0) ? 20'd1 : w_divisor;
  end

  // Restoring step: remainder stays below the divisor, so 20 bits hold it after subtracting.
  assign w_shift = {r_rem, r_quo[29]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_rem_n = w_ge ? (w_shift[19:0] - r_dvs) : w_shift[19:0];
  assign w_quo_n = {r_quo[28:0], w_ge};

  always_ff @(posedge vclock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_vsync_d <= 1'b1;
      r_step    <= '0;
      r_op_sx1  <= '0;
      r_op_sy1  <= '0;
      r_op_sx2  <= '0;
      r_op_sy2  <= '0;
      r_op_c1   <= '0;
      r_op_c2   <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_dvs     <= '0;
      r_q1x     <= '0;
      r_q1y     <= '0;
      r_q2x     <= '0;
      r_g1x     <= '0;
      r_g1y     <= '0;
      r_g2x     <= '0;
      r_g2y     <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_vsync_d <= bus.vsync;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_snap) begin
            r_op_sx1 <= r_sumx1;
            r_op_sy1 <= r_sumy1;
            r_op_c1  <= r_cnt1;
            r_op_sx2 <= r_sumx2;
            r_op_sy2 <= r_sumy2;
            r_op_c2  <= r_cnt2;
            r_step   <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_G1X;
          end
        end
        S_G1X, S_G1Y, S_G2X, S_G2Y: begin
          if (r_step == 5'd0) begin
            r_rem  <= '0;
            r_quo  <= w_dividend;
            r_dvs  <= w_divisor_f;
            r_step <= 5'd1;
          end else begin
            r_rem <= w_rem_n;
            r_quo <= w_quo_n;
            if (r_step == 5'd30) begin
              r_step <= '0;
              case (r_state)
                S_G1X: begin r_q1x <= w_quo_n[10:0]; r_state <= S_G1Y; end
                S_G1Y: begin r_q1y <= w_quo_n[9:0];  r_state <= S_G2X; end
                S_G2X: begin r_q2x <= w_quo_n[10:0]; r_state <= S_G2Y; end
                default: begin
                  if (r_op_c1 >= MIN_COUNT) begin
                    r_g1x <= r_q1x;
                    r_g1y <= r_q1y;
                    r_v1  <= 1'b1;
                  end else begin
                    r_v1  <= 1'b0;
                  end
                  if (r_op_c2 >= MIN_COUNT) begin
                    r_g2x <= r_q2x;
                    r_g2y <= w_quo_n[9:0];
                    r_v2  <= 1'b1;
                  end else begin
                    r_v2  <= 1'b0;
                  end
                  r_done  <= 1'b1;
                  r_state <= S_PUB;
                end
              endcase
            end else begin
              r_step <= r_step + 5'd1;
            end
          end
        end
        S_PUB: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.glove1x      = r_g1x;
  assign bus.glove1y      = r_g1y;
  assign bus.glove2x      = r_g2x;
  assign bus.glove2y      = r_g2y;
  assign bus.glove1_valid = r_v1;
  assign bus.glove2_valid = r_v2;
  assign bus.done         = r_done;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_glove_locator.sv
// tb/tb_glove_locator.sv - directed and randomized frames against a centroid reference model
// The model sums classified pixels with plain integers and divides at each frame end.
module tb_glove_locator;
  logic vclock = 1'b0;
  logic reset  = 1'b1;

  glove_locator_if bus ();

  glove_locator dut (
    .vclock (vclock),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 vclock = ~vclock;

  int total = 0;
  int bad   = 0;

  longint m_sx1, m_sy1, m_c1, m_sx2, m_sy2, m_c2;
  int     e_g1x, e_g1y, e_g2x, e_g2y;
  int     e_v1, e_v2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_marker(input logic [23:0] p, input int which);
    int r, g, b;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    if (which == 1) return (r >= 160) && (g <= 80) && (b <= 80);
    return (g >= 160) && (r <= 80) && (b <= 80);
  endfunction

  task automatic model_clear();
    m_sx1 = 0; m_sy1 = 0; m_c1 = 0;
    m_sx2 = 0; m_sy2 = 0; m_c2 = 0;
  endtask

  task automatic model_reset();
    model_clear();
    e_g1x = 0; e_g1y = 0; e_g2x = 0; e_g2y = 0;
    e_v1 = 0; e_v2 = 0;
  endtask

  task automatic model_publish();
    if (m_c1 >= 64) begin
      e_g1x = int'((m_sx1 / m_c1) % 2048);
      e_g1y = int'((m_sy1 / m_c1) % 1024);
      e_v1  = 1;
    end else begin
      e_v1  = 0;
    end
    if (m_c2 >= 64) begin
      e_g2x = int'((m_sx2 / m_c2) % 2048);
      e_g2y = int'((m_sy2 / m_c2) % 1024);
      e_v2  = 1;
    end else begin
      e_v2  = 0;
    end
    model_clear();
  endtask

  task automatic send_pix(input int h, input int v, input bit b, input logic [23:0] p);
    logic [31:0] hv, vv;
    hv = h;
    vv = v;
    bus.hcount = hv[10:0];
    bus.vcount = vv[9:0];
    bus.blank  = b;
    bus.pixel  = p;
    if (!b && is_marker(p, 1)) begin m_sx1 += h; m_sy1 += v; m_c1++; end
    if (!b && is_marker(p, 2)) begin m_sx2 += h; m_sy2 += v; m_c2++; end
    @(posedge vclock);
    #1;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_g1x"}, 32'(bus.glove1x), e_g1x);
    chk({tag, "_g1y"}, 32'(bus.glove1y), e_g1y);
    chk({tag, "_g2x"}, 32'(bus.glove2x), e_g2x);
    chk({tag, "_g2y"}, 32'(bus.glove2y), e_g2y);
    chk({tag, "_v1"},  32'(bus.glove1_valid), e_v1);
    chk({tag, "_v2"},  32'(bus.glove2_valid), e_v2);
  endtask

  task automatic red_square(input int count);
    int k;
    k = 0;
    for (int y = 200; y <= 215; y++)
      for (int x = 100; x <= 115; x++) begin
        if (k < count) send_pix(x, y, 1'b0, 24'hFF0000);
        k++;
      end
  endtask

  task automatic green_square();
    for (int y = 50; y <= 57; y++)
      for (int x = 600; x <= 607; x++) send_pix(x, y, 1'b0, 24'h00FF00);
  endtask

  // Falls vsync, then walks E+1..E+126 checking busy/done timing and the published values.
  task automatic end_frame(input string tag);
    bus.blank = 1'b1;
    bus.vsync = 1'b0;
    @(posedge vclock);
    model_publish();
    for (int n = 1; n <= 126; n++) begin
      @(negedge vclock);
      chk({tag, "_busy"}, 32'(bus.busy), (n <= 125) ? 1 : 0);
      chk({tag, "_done"}, 32'(bus.done), (n == 125) ? 1 : 0);
      if (n == 125) check_outputs(tag);
    end
    bus.vsync = 1'b1;
    @(posedge vclock);
    #1;
  endtask

  task automatic random_frame();
    int cx, cy, n, kind;
    logic [23:0] p;
    cx = $urandom_range(990, 30);
    cy = $urandom_range(730, 30);
    n  = $urandom_range(200, 60);
    for (int i = 0; i < n; i++) begin
      kind = $urandom_range(3, 0);
      case (kind)
        0: p = {8'($urandom_range(255, 150)), 8'($urandom_range(90, 0)), 8'($urandom_range(90, 0))};
        1: p = {8'($urandom_range(90, 0)), 8'($urandom_range(255, 150)), 8'($urandom_range(90, 0))};
        default: p = 24'($urandom);
      endcase
      send_pix(cx + $urandom_range(40, 0) - 20, cy + $urandom_range(40, 0) - 20, (kind == 3), p);
    end
  endtask

  initial begin
    bus.hcount = '0;
    bus.vcount = '0;
    bus.vsync  = 1'b1;
    bus.blank  = 1'b1;
    bus.pixel  = '0;
    model_reset();

    repeat (2) @(posedge vclock);
    #1;
    reset = 1'b0;
    @(negedge vclock);
    check_outputs("reset");
    chk("reset_done", 32'(bus.done), 0);
    chk("reset_busy", 32'(bus.busy), 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge vclock);
      chk("idle_done", 32'(bus.done), 0);
    end
    @(posedge vclock);
    #1;

    red_square(256);
    end_frame("A");
    chk("A_g1x_const", 32'(bus.glove1x), 107);
    chk("A_g1y_const", 32'(bus.glove1y), 207);

    red_square(256);
    green_square();
    end_frame("B");
    chk("B_g2x_const", 32'(bus.glove2x), 603);
    chk("B_g2y_const", 32'(bus.glove2y), 53);
    chk("B_v2_const",  32'(bus.glove2_valid), 1);

    red_square(63);
    end_frame("C");
    chk("C_g1x_hold", 32'(bus.glove1x), 107);
    chk("C_v1_const", 32'(bus.glove1_valid), 0);

    for (int i = 0; i < 40; i++) begin
      send_pix(900 + i, 700, 1'b1, 24'hFF0000);
      send_pix(20 + i, 10, 1'b0, 24'hC86400);
    end
    red_square(256);
    end_frame("D");
    chk("D_g1x_const", 32'(bus.glove1x), 107);

    red_square(256);
    green_square();
    bus.blank = 1'b1;
    bus.vsync = 1'b0;
    @(posedge vclock);
    repeat (60) @(negedge vclock);
    reset     = 1'b1;
    bus.vsync = 1'b1;
    @(posedge vclock);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 140; i++) begin
      @(negedge vclock);
      chk("abort_done", 32'(bus.done), 0);
      chk("abort_busy", 32'(bus.busy), 0);
    end
    check_outputs("abort");
    @(posedge vclock);
    #1;

    red_square(256);
    end_frame("F");
    chk("F_g1x_const", 32'(bus.glove1x), 107);
    chk("F_g1y_const", 32'(bus.glove1y), 207);

    for (int f = 0; f < 4; f++) begin
      random_frame();
      end_frame("R");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
